a2d_req_arbiter: RTL
====================

// Module: a2d_req_arbiter
// PURPOSE
// Shares the single A2D converter interface (strt_cnv/chnnl/cnv_cmplt/A2D_res)
// between NUM_REQ requesters, e.g. motion controller IR sampling and battery
// monitoring. Uses round-robin arbitration, latches the channel per request,
// sequences one conversion at a time and returns the result to the owner.
// Sits between the requesters and the A2D SPI front end.
// PARAMETERS
// NUM_REQ      2     number of requesters, legal 2..4
// TIMEOUT_CYC  1024  WAIT-state cycle limit (used only with A2D_ARB_TIMEOUT_EN)
// PORTS
// clk        in   1            system clock
// rst_n      in   1            asynchronous active-low reset
// req        in   NUM_REQ      level request per requester; hold high until done
// req_chnnl  in   3*NUM_REQ    channel per requester, [3i+2:3i] for requester i
// gnt        out  NUM_REQ      one-hot; owner bit high from START through DONE
// done       out  NUM_REQ      one-cycle pulse to owner when res is valid
// res        out  12           last conversion result, shared by all requesters
// busy       out  1            high in every state except IDLE
// tmo        out  1            one-cycle timeout pulse; tied 0 without macro
// strt_cnv   out  1            one-cycle start pulse to A2D
// chnnl      out  3            channel to A2D; held stable START..DONE
// cnv_cmplt  in   1            A2D conversion complete strobe
// A2D_res    in   12           A2D result, valid while cnv_cmplt is high
// BEHAVIOUR
// - Reset: state=IDLE; gnt, done, res, busy, tmo, strt_cnv, chnnl all 0;
//   last_gnt=NUM_REQ-1, so requester 0 wins first. Reset is honoured in any
//   state; an in-flight conversion is abandoned with no done pulse.
// - FSM IDLE->START->WAIT->DONE->IDLE; all outputs are registered.
// - IDLE: if |req, select the first set req index scanning last_gnt+1 upward
//   with wrap. Latch owner and req_chnnl[owner] into chnnl, then go to START.
//   A cnv_cmplt seen in IDLE is ignored.
// - START: exactly one cycle; strt_cnv=1, then go to WAIT.
// - WAIT: on cnv_cmplt, res<=A2D_res and go to DONE. A cnv_cmplt in START
//   is ignored.
// - DONE: exactly one cycle; done[owner]=1, last_gnt<=owner, then go to IDLE.
// - Latency: req rises in IDLE at cycle N -> strt_cnv at N+1 -> WAIT from
//   N+2 -> done in the cycle after cnv_cmplt is sampled.
// - A req that is still high in the IDLE after DONE is treated as a new
//   request. Round-robin guarantees the other requesters are served first.
// - Dropping req mid-conversion does not abort: the conversion completes and
//   done is still pulsed. A req_chnnl change after latch has no effect.
// - res holds its value until the next completed conversion. Minimum
//   back-to-back period is 4 cycles plus the A2D time.
// CONFIGURATION
// - A2D_ARB_TIMEOUT_EN defined: a 10+ bit counter clears on WAIT entry and
//   counts each WAIT cycle. When it reaches TIMEOUT_CYC-1 without cnv_cmplt,
//   go to DONE with done[owner]=1 and tmo=1 in that same cycle; res is
//   unchanged. A cnv_cmplt in the same cycle as the limit takes priority
//   (normal completion, tmo=0).
// - Macro undefined: no counter; WAIT waits indefinitely; tmo constant 0.
// TESTING
// 1. req0=1, req_chnnl0=3'd4, cnv_cmplt 20 cycles after strt_cnv with
//    A2D_res=12'hABC -> one strt_cnv pulse, chnnl=4, gnt=2'b01, next cycle
//    done=2'b01, res=12'hABC.
// 2. req=2'b11 from reset, ch0=1, ch1=7 -> requester 0 served first
//    (chnnl=1), then requester 1 (chnnl=7); exactly one done per owner.
// 3. req=2'b11 held for 4 conversions -> grant order 0,1,0,1; strt_cnv never
//    issued while busy=1.
// 4. rst_n low during WAIT -> all outputs 0 immediately, no done. After
//    release, req1 alone gets the first grant (last_gnt=1 rule yields 0 first
//    only if 0 requests).
// 5. Macro on, TIMEOUT_CYC=16, cnv_cmplt never arrives -> done and tmo pulse
//    16 cycles after WAIT entry, res unchanged. Macro off -> busy stays 1.
// 6. cnv_cmplt pulsed in IDLE and START with A2D_res=12'h123 -> res not
//    updated, no done.

Source files
------------

// File: rtl/a2d_req_arbiter_if.sv
// a2d_req_arbiter_if: requester-side and A2D-side signals of the arbiter.
// master = requesters plus A2D front end, slave = arbiter.
interface a2d_req_arbiter_if #(
  parameter int NUM_REQ = 2
) ();
  logic [NUM_REQ-1:0]   req;
  logic [3*NUM_REQ-1:0] req_chnnl;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [11:0]          res;
  logic                 busy;
  logic                 tmo;
  logic                 strt_cnv;
  logic [2:0]           chnnl;
  logic                 cnv_cmplt;
  logic [11:0]          A2D_res;

  modport master (
    output req, req_chnnl, cnv_cmplt, A2D_res,
    input  gnt, done, res, busy, tmo, strt_cnv, chnnl
  );

  modport slave (
    input  req, req_chnnl, cnv_cmplt, A2D_res,
    output gnt, done, res, busy, tmo, strt_cnv, chnnl
  );
endinterface

// File: rtl/a2d_req_arbiter.sv
// a2d_req_arbiter: round-robin sharing of one A2D converter between requesters.
// Define A2D_ARB_TIMEOUT_EN to abandon a conversion after TIMEOUT_CYC WAIT cycles.
module a2d_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic          clk,
  input logic          rst_n,
  a2d_req_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam int LP_W = IW + 1;
  localparam logic [LP_W-1:0] LP_NR = LP_W'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_last;
  logic [IW-1:0]      w_pick;
  logic [IW-1:0]      w_owner_nxt;
  logic [LP_W-1:0]    w_idx;
  logic               w_found;
  logic               w_tmo_hit;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic [2:0]         r_chnnl;
  logic [11:0]        r_res;
  logic               r_busy;
  logic               r_strt;

  // scan starts one past the last owner so every requester gets a turn
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, r_last} + LP_W'(k);
      if (w_idx >= LP_NR) w_idx = w_idx - LP_NR;
      if (!w_found && bus.req[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.cnv_cmplt || w_tmo_hit) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_owner_nxt = (r_state == S_IDLE) ? w_pick : r_owner;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    if (w_state_nxt != S_IDLE) w_gnt_nxt[w_owner_nxt] = 1'b1;
    if (w_state_nxt == S_DONE) w_done_nxt[w_owner_nxt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_strt  <= 1'b0;
      r_owner <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_chnnl <= '0;
      r_res   <= '0;
    end else begin
      r_gnt  <= w_gnt_nxt;
      r_done <= w_done_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      r_strt <= (w_state_nxt == S_START);
      if (r_state == S_IDLE && w_found) begin
        r_owner <= w_pick;
        r_chnnl <= bus.req_chnnl[3*int'(w_pick) +: 3];
      end
      if (r_state == S_WAIT && bus.cnv_cmplt) r_res <= bus.A2D_res;
      if (r_state == S_DONE) r_last <= r_owner;
    end
  end

`ifdef A2D_ARB_TIMEOUT_EN
  localparam int LOG_TMO = $clog2(TIMEOUT_CYC);
  localparam int CW = (LOG_TMO > 10) ? LOG_TMO : 10;

  logic [CW-1:0] r_cnt;
  logic          r_tmo;

  // counter sits at zero outside WAIT, so it is clear on WAIT entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      if (r_state != S_WAIT) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
      r_tmo <= w_tmo_hit && !bus.cnv_cmplt;
    end
  end

  assign w_tmo_hit = (r_state == S_WAIT) &&
                     (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign bus.tmo   = r_tmo;
`else
  assign w_tmo_hit = 1'b0;
  assign bus.tmo   = 1'b0;
`endif

  assign bus.gnt      = r_gnt;
  assign bus.done     = r_done;
  assign bus.res      = r_res;
  assign bus.busy     = r_busy;
  assign bus.strt_cnv = r_strt;
  assign bus.chnnl    = r_chnnl;
endmodule
